// File: rtl/usb_tx_nrzi_stuff_encoder_if.sv
// Byte handshake between the TX packet/CRC logic and the USB line encoder.
interface usb_tx_nrzi_stuff_encoder_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      output tx_last,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      input  tx_last,
      output tx_ready
   );
endinterface

// File: rtl/usb_tx_nrzi_stuff_encoder.sv
// Full-speed USB TX line encoder: LSB-first serialiser with NRZI, bit stuffing and EOP.
// Bytes arrive through a one-deep holding register so consecutive bytes leave with no gap.
module usb_tx_nrzi_stuff_encoder #(
   parameter int CLKS_PER_BIT = 8,
   parameter int STUFF_LEN    = 6,
   parameter int EOP_SE0_BITS = 2
) (
   input  logic                        clk,
   input  logic                        n_rst,
   usb_tx_nrzi_stuff_encoder_if.slave  tx,
   output logic                        dplus_out,
   output logic                        dminus_out,
   output logic                        encode_busy,
   output logic                        tx_underrun
);
   localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int ONES_W = $clog2(STUFF_LEN + 1);
   localparam int EOP_W  = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;

   localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [ONES_W-1:0] ONES_STUFF = ONES_W'(STUFF_LEN);
   localparam logic [EOP_W-1:0]  SE0_LAST   = EOP_W'(EOP_SE0_BITS - 1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] SHIFT   = 3'd1;
   localparam logic [2:0] STUFF   = 3'd2;
   localparam logic [2:0] EOP_SE0 = 3'd3;
   localparam logic [2:0] EOP_J   = 3'd4;

   logic [2:0]        state, state_nxt;
   logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
   logic [2:0]        bit_idx, bit_idx_nxt, bit_idx_inc;
   logic [ONES_W-1:0] ones_cnt, ones_nxt;
   logic [EOP_W-1:0]  eop_cnt, eop_cnt_nxt;
   logic              hold_full, hold_full_nxt;
   logic [7:0]        hold_data, shift_reg;
   logic              hold_last, cur_last;
   logic              dplus_nxt, dminus_nxt, busy_nxt, underrun_nxt;
   logic              boundary, accept, load, send_bit, tx_bit, byte_end;

   // Run length of transmitted ones; any transmitted zero restarts it.
   function automatic logic [ONES_W-1:0] ones_after(input logic bit_val,
                                                    input logic [ONES_W-1:0] cnt);
      return bit_val ? cnt + 1'b1 : '0;
   endfunction

   assign boundary    = (bit_cnt == BIT_LAST);
   assign bit_idx_inc = bit_idx + 3'd1;
   assign accept      = tx.tx_valid & ~hold_full;
   assign tx.tx_ready = ~hold_full;

   always_comb begin
      state_nxt     = state;
      bit_cnt_nxt   = boundary ? '0 : bit_cnt + 1'b1;
      bit_idx_nxt   = bit_idx;
      ones_nxt      = ones_cnt;
      eop_cnt_nxt   = eop_cnt;
      hold_full_nxt = hold_full;
      dplus_nxt     = dplus_out;
      dminus_nxt    = dminus_out;
      busy_nxt      = encode_busy;
      underrun_nxt  = 1'b0;
      load          = 1'b0;
      send_bit      = 1'b0;
      tx_bit        = 1'b0;
      byte_end      = 1'b0;

      case (state)
         IDLE: begin
            bit_cnt_nxt = '0;
            ones_nxt    = '0;
            dplus_nxt   = 1'b1;
            dminus_nxt  = 1'b0;
            if (hold_full) begin
               load     = 1'b1;
               busy_nxt = 1'b1;
            end
         end
         SHIFT: begin
            if (boundary) begin
               if (ones_cnt == ONES_STUFF) begin
                  state_nxt  = STUFF;
                  dplus_nxt  = ~dplus_out;
                  dminus_nxt = ~dminus_out;
                  ones_nxt   = '0;
               end else if (bit_idx != 3'd7) begin
                  bit_idx_nxt = bit_idx_inc;
                  send_bit    = 1'b1;
                  tx_bit      = shift_reg[bit_idx_inc];
               end else begin
                  byte_end = 1'b1;
               end
            end
         end
         STUFF: begin
            if (boundary) begin
               if (bit_idx != 3'd7) begin
                  state_nxt   = SHIFT;
                  bit_idx_nxt = bit_idx_inc;
                  send_bit    = 1'b1;
                  tx_bit      = shift_reg[bit_idx_inc];
               end else begin
                  byte_end = 1'b1;
               end
            end
         end
         EOP_SE0: begin
            if (boundary) begin
               if (eop_cnt == SE0_LAST) begin
                  state_nxt  = EOP_J;
                  dplus_nxt  = 1'b1;
                  dminus_nxt = 1'b0;
               end else begin
                  eop_cnt_nxt = eop_cnt + 1'b1;
               end
            end
         end
         EOP_J: begin
            if (boundary) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
            end
         end
         default: begin
            state_nxt  = IDLE;
            busy_nxt   = 1'b0;
            dplus_nxt  = 1'b1;
            dminus_nxt = 1'b0;
         end
      endcase

      // A byte that ends with nothing queued either closes the packet or aborts it.
      if (byte_end) begin
         if (hold_full) begin
            load = 1'b1;
         end else begin
            state_nxt    = EOP_SE0;
            dplus_nxt    = 1'b0;
            dminus_nxt   = 1'b0;
            eop_cnt_nxt  = '0;
            ones_nxt     = '0;
            underrun_nxt = ~cur_last;
         end
      end

      if (load) begin
         state_nxt     = SHIFT;
         bit_idx_nxt   = 3'd0;
         hold_full_nxt = 1'b0;
         send_bit      = 1'b1;
         tx_bit        = hold_data[0];
      end else if (accept) begin
         hold_full_nxt = 1'b1;
      end

      // NRZI: a zero toggles J<->K, a one keeps the current level.
      if (send_bit) begin
         ones_nxt = ones_after(tx_bit, (state == IDLE) ? '0 : ones_cnt);
         if (!tx_bit) begin
            dplus_nxt  = ~dplus_nxt;
            dminus_nxt = ~dminus_nxt;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         bit_idx     <= 3'd0;
         ones_cnt    <= '0;
         eop_cnt     <= '0;
         hold_full   <= 1'b0;
         dplus_out   <= 1'b1;
         dminus_out  <= 1'b0;
         encode_busy <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         state       <= state_nxt;
         bit_cnt     <= bit_cnt_nxt;
         bit_idx     <= bit_idx_nxt;
         ones_cnt    <= ones_nxt;
         eop_cnt     <= eop_cnt_nxt;
         hold_full   <= hold_full_nxt;
         dplus_out   <= dplus_nxt;
         dminus_out  <= dminus_nxt;
         encode_busy <= busy_nxt;
         tx_underrun <= underrun_nxt;
      end
   end

   // Byte storage is qualified by hold_full and the state, so it needs no reset.
   always_ff @(posedge clk) begin
      if (load) begin
         shift_reg <= hold_data;
         cur_last  <= hold_last;
      end
      if (accept) begin
         hold_data <= tx.tx_data;
         hold_last <= tx.tx_last;
      end
   end
endmodule

// File: tb/tb_usb_tx_nrzi_stuff_encoder.sv
// Scoreboard bench for the USB TX line encoder: two instances (default and CLKS_PER_BIT=4/STUFF_LEN=3).
module tb_usb_tx_nrzi_stuff_encoder;
   typedef struct packed { int len; bit und; } pkt_t;

   logic clk;
   logic n_rst;
   bit   sel;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   acc_cyc = -1;

   logic dp0, dm0, busy0, und0;
   logic dp1, dm1, busy1, und1;

   usb_tx_nrzi_stuff_encoder_if if0 ();
   usb_tx_nrzi_stuff_encoder_if if1 ();

   usb_tx_nrzi_stuff_encoder #(.CLKS_PER_BIT(8), .STUFF_LEN(6), .EOP_SE0_BITS(2)) u0 (
      .clk(clk), .n_rst(n_rst), .tx(if0),
      .dplus_out(dp0), .dminus_out(dm0), .encode_busy(busy0), .tx_underrun(und0));

   usb_tx_nrzi_stuff_encoder #(.CLKS_PER_BIT(4), .STUFF_LEN(3), .EOP_SE0_BITS(2)) u1 (
      .clk(clk), .n_rst(n_rst), .tx(if1),
      .dplus_out(dp1), .dminus_out(dm1), .encode_busy(busy1), .tx_underrun(und1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   logic [1:0] sym_q[$];
   pkt_t       pkt_q[$];

   function automatic void chk(input string nm, input int act, input int exp);
      total = total + 1;
      if (act != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
      end
   endfunction

   function automatic logic [1:0] cur_line();
      return sel ? {dp1, dm1} : {dp0, dm0};
   endfunction

   function automatic logic cur_busy();
      return sel ? busy1 : busy0;
   endfunction

   function automatic logic cur_ready();
      return sel ? if1.tx_ready : if0.tx_ready;
   endfunction

   // J=2'b10, K=2'b01, S(E0)=2'b00
   task automatic push_exp(input string s, input bit und);
      pkt_t p;
      for (int i = 0; i < s.len(); i++) begin
         case (s[i])
            "J":     sym_q.push_back(2'b10);
            "K":     sym_q.push_back(2'b01);
            default: sym_q.push_back(2'b00);
         endcase
      end
      p.len = s.len();
      p.und = und;
      pkt_q.push_back(p);
   endtask

   task automatic drive(input logic [7:0] d, input logic l, input logic v);
      if (sel) begin
         if1.tx_data = d; if1.tx_last = l; if1.tx_valid = v;
      end else begin
         if0.tx_data = d; if0.tx_last = l; if0.tx_valid = v;
      end
   endtask

   task automatic send(input logic [7:0] d, input bit l, input bit keep, input bit first);
      int n;
      bit r;
      n = 0;
      @(negedge clk);
      drive(d, l, 1'b1);
      forever begin
         r = cur_ready();
         @(posedge clk);
         if (r) break;
         n++;
         if (n > 3000) begin
            chk("accept_timeout", 0, 1);
            break;
         end
         @(negedge clk);
      end
      #1;
      if (r && first) acc_cyc = cyc;
      if (!keep) drive(d, l, 1'b0);
      @(negedge clk);
      chk("ready_low_after_accept", cur_ready(), 0);
   endtask

   task automatic wait_idle();
      int low;
      int n;
      low = 0;
      n = 0;
      while (low < 3 && n < 3000) begin
         @(negedge clk);
         n++;
         low = cur_busy() ? 0 : low + 1;
      end
      chk("idle_reached", (low >= 3) ? 1 : 0, 1);
      @(posedge clk);
      #1;
   endtask

   // Monitor: one expected symbol per bit period, checked on every clock of that period.
   bit         in_pkt = 0;
   bit         se0_seen;
   bit         first_se0;
   int         k;
   int         periods;
   int         cpb;
   logic [1:0] exp_sym;
   pkt_t       cur;

   initial forever begin
      @(negedge clk);
      cpb = sel ? 4 : 8;
      if (!n_rst) begin
         in_pkt = 0;
         sym_q.delete();
         pkt_q.delete();
      end else if (cur_busy()) begin
         if (!in_pkt) begin
            in_pkt   = 1;
            k        = 0;
            periods  = 0;
            se0_seen = 0;
            if (pkt_q.size() == 0) begin
               chk("unexpected_packet", 1, 0);
               cur = '{len: 0, und: 1'b0};
            end else begin
               cur = pkt_q.pop_front();
            end
            if (acc_cyc >= 0) chk("start_latency", cyc - acc_cyc, 1);
            acc_cyc = -1;
         end
         if (k == 0) begin
            if (periods < cur.len && sym_q.size() > 0) exp_sym = sym_q.pop_front();
            else exp_sym = 2'b11;
            first_se0 = (exp_sym == 2'b00) && !se0_seen;
            if (exp_sym == 2'b00) se0_seen = 1;
            periods++;
         end
         chk($sformatf("line_p%0d", periods), cur_line(), exp_sym);
         chk("underrun", sel ? und1 : und0, (cur.und && first_se0 && k == 0) ? 1 : 0);
         k = (k == cpb - 1) ? 0 : k + 1;
      end else begin
         if (in_pkt) begin
            chk("packet_periods", periods, cur.len);
            chk("packet_last_period_len", k, 0);
            in_pkt = 0;
         end
         chk("idle_line_j", cur_line(), 2'b10);
         chk("idle_underrun", sel ? und1 : und0, 0);
      end
   end

   initial begin
      sel   = 1'b0;
      n_rst = 1'b0;
      if0.tx_valid = 1'b0; if0.tx_data = 8'h00; if0.tx_last = 1'b0;
      if1.tx_valid = 1'b0; if1.tx_data = 8'h00; if1.tx_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dplus", dp0, 1);
      chk("rst_dminus", dm0, 0);
      chk("rst_ready", if0.tx_ready, 1);
      chk("rst_busy", busy0, 0);
      chk("rst_underrun", und0, 0);
      chk("rst_dplus_b", dp1, 1);
      chk("rst_ready_b", if1.tx_ready, 1);
      n_rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // 0x80: seven zeros toggle, final one holds
      push_exp("KJKJKJKKSSJ", 1'b0);
      send(8'h80, 1'b1, 1'b0, 1'b1);
      wait_idle();

      // 0xFF: six ones, stuffed K, two more ones
      push_exp("JJJJJJKKKSSJ", 1'b0);
      send(8'hFF, 1'b1, 1'b0, 1'b1);
      wait_idle();

      // 0x80 then 0x3F back to back: ones run spans the byte boundary
      push_exp("KJKJKJKKKKKKKJJKJSSJ", 1'b0);
      send(8'h80, 1'b0, 1'b1, 1'b1);
      send(8'h3F, 1'b1, 1'b0, 1'b0);
      wait_idle();

      // non-last byte with nothing behind it
      push_exp("KJKJKJKKSSJ", 1'b1);
      send(8'h80, 1'b0, 1'b0, 1'b1);
      wait_idle();

      // second packet accepted during the first packet's SE0
      push_exp("KJKJKJKKSSJ", 1'b0);
      push_exp("JKJKJKJKSSJ", 1'b0);
      send(8'h80, 1'b1, 1'b0, 1'b1);
      repeat (70) @(posedge clk);
      #1;
      send(8'h01, 1'b1, 1'b0, 1'b0);
      wait_idle();

      // reset in the middle of a packet
      push_exp("JJJJJJKKKSSJ", 1'b0);
      send(8'hFF, 1'b1, 1'b0, 1'b1);
      repeat (20) @(posedge clk);
      #2;
      chk("busy_before_abort", busy0, 1);
      n_rst = 1'b0;
      #1;
      chk("abort_dplus", dp0, 1);
      chk("abort_dminus", dm0, 0);
      chk("abort_ready", if0.tx_ready, 1);
      chk("abort_busy", busy0, 0);
      chk("abort_underrun", und0, 0);
      repeat (2) @(posedge clk);
      #2;
      n_rst = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("post_reset_dplus", dp0, 1);
      chk("post_reset_dminus", dm0, 0);
      chk("post_reset_busy", busy0, 0);

      // CLKS_PER_BIT=4, STUFF_LEN=3: 0x07
      sel = 1'b1;
      push_exp("JJJKJKJKJSSJ", 1'b0);
      send(8'h07, 1'b1, 1'b0, 1'b1);
      wait_idle();
      chk("sweep_queue_drained", sym_q.size(), 0);

      repeat (5) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
